// File: rtl/tcdm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tcdm_arb_pkg
//  Description : Shared width helpers, default geometry and the per-master
//                request bundle used by the TCDM bank round-robin arbiter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Contents    : calc_addr_w / calc_be_w / calc_ptr_w width helpers,
//                TCDM_* default geometry, tcdm_req_t request bundle.
// ============================================================================
package tcdm_arb_pkg;

  // Width of a word address for a bank of bank_size words (at least 1 bit).
  function automatic int calc_addr_w(input int bank_size);
    return (bank_size > 1) ? $clog2(bank_size) : 1;
  endfunction

  // Number of byte enables for a data word.
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Width of the round-robin pointer / grant index (at least 1 bit).
  function automatic int calc_ptr_w(input int nb_masters);
    return (nb_masters > 1) ? $clog2(nb_masters) : 1;
  endfunction

  // Bank geometry the request bundle is sized for. The arbiter's BANK_SIZE
  // and DATA_W parameters default to these and must stay equal to them,
  // because a packed struct cannot follow a module parameter.
  localparam int TCDM_BANK_SIZE = 256;
  localparam int TCDM_DATA_W    = 32;
  localparam int TCDM_ADDR_W    = calc_addr_w(TCDM_BANK_SIZE);
  localparam int TCDM_BE_W      = calc_be_w(TCDM_DATA_W);
  localparam int TCDM_PERF_W    = 16;

  // One master's bank-side request, muxed as a unit onto the bank port.
  typedef struct packed {
    logic [TCDM_ADDR_W-1:0] add;
    logic                   wen;   // active-low: 1 = read
    logic [TCDM_DATA_W-1:0] wdata;
    logic [TCDM_BE_W-1:0]   be;
  } tcdm_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_prio_sel.sv
`default_nettype none
// ============================================================================
//  Module      : rr_prio_sel
//  Description : Combinational rotating-priority selector. Scans req starting
//                at rr_ptr, wrapping modulo NB_REQ, and picks the first set bit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : req    [NB_REQ]  request vector
//                rr_ptr [PTR_W]   index with highest priority this cycle
//                gnt    [NB_REQ]  one-hot grant (all zero when req == 0)
//                idx    [PTR_W]   binary index of the granted bit
//                valid  [1]       any grant given
// ============================================================================
module rr_prio_sel #(
  parameter int NB_REQ = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NB_REQ-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              valid
);

  // One spare bit so rr_ptr + offset (at most 2*NB_REQ-2) never overflows
  // before the modulo correction.
  logic [PTR_W:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 0; off < NB_REQ; off++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NB_REQ)) begin
        cand = cand - (PTR_W+1)'(NB_REQ);
      end
      if (!valid && req[cand[PTR_W-1:0]]) begin
        valid                 = 1'b1;
        gnt[cand[PTR_W-1:0]]  = 1'b1;
        idx                   = cand[PTR_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcdm_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tcdm_bank_rr_arbiter
//  Description : Round-robin arbiter sharing one single-port TCDM bank
//                (1-cycle read latency) between NB_MASTERS requesters. One
//                bank access per cycle; response valid is returned to the
//                granted master one cycle after its grant.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : clk_i, rst_i (sync, active-high)
//                req_i/add_i/wen_i/wdata_i/be_i  per-master request
//                gnt_o        one-hot grant, combinational
//                r_valid_o    one-hot response valid, cycle after grant
//                r_rdata_o    shared response data (bank passthrough)
//                bank_*_o     bank request side, bank_rdata_i bank read data
//  Option      : TCDM_ARB_PERF_EN adds perf_clr_i and perf_stall_o, per-master
//                saturating 16-bit counters of cycles spent requesting
//                without a grant.
//  Note        : BANK_SIZE and DATA_W must match TCDM_BANK_SIZE and
//                TCDM_DATA_W in tcdm_arb_pkg (request bundle widths).
// ============================================================================
module tcdm_bank_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int NB_MASTERS = 4,
  parameter int BANK_SIZE  = TCDM_BANK_SIZE,
  parameter int DATA_W     = TCDM_DATA_W,
  localparam int ADDR_W    = calc_addr_w(BANK_SIZE),
  localparam int BE_W      = calc_be_w(DATA_W),
  localparam int PTR_W     = calc_ptr_w(NB_MASTERS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_MASTERS-1:0]              req_i,
  input  logic [NB_MASTERS-1:0][ADDR_W-1:0]  add_i,
  input  logic [NB_MASTERS-1:0]              wen_i,
  input  logic [NB_MASTERS-1:0][DATA_W-1:0]  wdata_i,
  input  logic [NB_MASTERS-1:0][BE_W-1:0]    be_i,
  output logic [NB_MASTERS-1:0]              gnt_o,
  output logic [NB_MASTERS-1:0]              r_valid_o,
  output logic [DATA_W-1:0]                  r_rdata_o,
  output logic                               bank_req_o,
  output logic                               bank_wen_o,
  output logic [ADDR_W-1:0]                  bank_add_o,
  output logic [DATA_W-1:0]                  bank_wdata_o,
  output logic [BE_W-1:0]                    bank_be_o,
  input  logic [DATA_W-1:0]                  bank_rdata_i
`ifdef TCDM_ARB_PERF_EN
  ,
  input  logic                               perf_clr_i,
  output logic [NB_MASTERS-1:0][TCDM_PERF_W-1:0] perf_stall_o
`endif
);

  logic [PTR_W-1:0]      rr_ptr;
  logic [NB_MASTERS-1:0] gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [NB_MASTERS-1:0] r_valid_q;
  tcdm_req_t             reqs [NB_MASTERS];
  tcdm_req_t             sel;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  rr_prio_sel #(
    .NB_REQ (NB_MASTERS),
    .PTR_W  (PTR_W)
  ) u_prio_sel (
    .req    (req_i),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .idx    (gnt_idx),
    .valid  (gnt_any)
  );

  assign gnt_o = gnt;

  // The winner gets lowest priority next: pointer moves just past it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == PTR_W'(NB_MASTERS-1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request mux onto the bank port
  // --------------------------------------------------------------------------
  for (genvar m = 0; m < NB_MASTERS; m++) begin : g_pack
    assign reqs[m] = '{add:   add_i[m],
                       wen:   wen_i[m],
                       wdata: wdata_i[m],
                       be:    be_i[m]};
  end

  assign sel = reqs[gnt_idx];

  // Idle bank port is a quiet read (wen high) with everything else zero.
  always_comb begin
    bank_req_o   = 1'b0;
    bank_wen_o   = 1'b1;
    bank_add_o   = '0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    if (gnt_any) begin
      bank_req_o   = 1'b1;
      bank_wen_o   = sel.wen;
      bank_add_o   = sel.add;
      bank_wdata_o = sel.wdata;
      bank_be_o    = sel.be;
    end
  end

  // --------------------------------------------------------------------------
  // Response path: valid follows the grant by the bank's one-cycle latency,
  // for writes as well as reads. Read data is a straight passthrough.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= '0;
    end else begin
      r_valid_q <= gnt;
    end
  end

  assign r_valid_o = r_valid_q;
  assign r_rdata_o = bank_rdata_i;

  // --------------------------------------------------------------------------
  // Optional stall counters
  // --------------------------------------------------------------------------
`ifdef TCDM_ARB_PERF_EN
  for (genvar m = 0; m < NB_MASTERS; m++) begin : g_perf
    logic [TCDM_PERF_W-1:0] stall_cnt;

    // Clear wins over increment; counter sticks at all-ones.
    always_ff @(posedge clk_i) begin
      if (rst_i || perf_clr_i) begin
        stall_cnt <= '0;
      end else if (req_i[m] && !gnt[m] && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end

    assign perf_stall_o[m] = stall_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcdm_bank_rr_arbiter
//  Description : Self-checking bench for tcdm_bank_rr_arbiter with a bank
//                memory model and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_bank_rr_arbiter;

  localparam int NB = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NB-1:0]          req;
  logic [NB-1:0][AW-1:0]  add;
  logic [NB-1:0]          wen;
  logic [NB-1:0][DW-1:0]  wdata;
  logic [NB-1:0][BW-1:0]  be;
  logic [NB-1:0]          gnt;
  logic [NB-1:0]          r_valid;
  logic [DW-1:0]          r_rdata;
  logic                   bank_req;
  logic                   bank_wen;
  logic [AW-1:0]          bank_add;
  logic [DW-1:0]          bank_wdata;
  logic [BW-1:0]          bank_be;
  logic [DW-1:0]          bank_rdata;
`ifdef TCDM_ARB_PERF_EN
  logic                   perf_clr;
  logic [NB-1:0][15:0]    perf_stall;
`endif

  tcdm_bank_rr_arbiter #(
    .NB_MASTERS (NB),
    .BANK_SIZE  (256),
    .DATA_W     (DW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .add_i        (add),
    .wen_i        (wen),
    .wdata_i      (wdata),
    .be_i         (be),
    .gnt_o        (gnt),
    .r_valid_o    (r_valid),
    .r_rdata_o    (r_rdata),
    .bank_req_o   (bank_req),
    .bank_wen_o   (bank_wen),
    .bank_add_o   (bank_add),
    .bank_wdata_o (bank_wdata),
    .bank_be_o    (bank_be),
    .bank_rdata_i (bank_rdata)
`ifdef TCDM_ARB_PERF_EN
    ,
    .perf_clr_i   (perf_clr),
    .perf_stall_o (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Bank model: single-port SRAM, byte-enabled write, 1-cycle read latency.
  logic [DW-1:0] sram [256];
  always @(posedge clk) begin
    if (bank_req) begin
      if (!bank_wen) begin
        for (int b = 0; b < BW; b++) begin
          if (bank_be[b]) sram[bank_add][8*b +: 8] <= bank_wdata[8*b +: 8];
        end
      end else begin
        bank_rdata <= sram[bank_add];
      end
    end
  end

  // Reference model state
  int            n_tests;
  int            n_fail;
  int            m_ptr;
  logic [DW-1:0] ref_mem [256];

  // Expected / observed values for the cycle just run
  logic [NB-1:0] exp_gnt, obs_gnt, exp_rvalid, obs_rvalid;
  logic [DW+AW+BW+1:0] exp_bus, obs_bus;
  logic          exp_rd_chk;
  logic [DW-1:0] exp_rdata, obs_rdata;

  function automatic int ref_winner(input logic [NB-1:0] r, input int p);
    for (int o = 0; o < NB; o++) begin
      if (r[(p + o) % NB]) return (p + o) % NB;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] bes);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < BW; b++) begin
      if (bes[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Runs one clock cycle with the currently driven inputs. Entered and left
  // at posedge+1. Combinational outputs are sampled at the negedge, response
  // outputs 1 time unit after the closing posedge.
  task automatic cycle();
    int w;
    w          = ref_winner(req, m_ptr);
    exp_gnt    = '0;
    exp_bus    = {1'b0, 1'b1, {AW{1'b0}}, {DW{1'b0}}, {BW{1'b0}}};
    exp_rd_chk = 1'b0;
    exp_rdata  = '0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      exp_bus    = {1'b1, wen[w], add[w], wdata[w], be[w]};
    end
    @(negedge clk);
    obs_gnt = gnt;
    obs_bus = {bank_req, bank_wen, bank_add, bank_wdata, bank_be};
    exp_rvalid = rst ? '0 : exp_gnt;
    if (w >= 0 && wen[w] && !rst) begin
      exp_rd_chk = 1'b1;
      exp_rdata  = ref_mem[add[w]];
    end
    if (w >= 0 && !wen[w]) ref_mem[add[w]] = merge(ref_mem[add[w]], wdata[w], be[w]);
    if (rst)         m_ptr = 0;
    else if (w >= 0) m_ptr = (w + 1) % NB;
    @(posedge clk);
    #1;
    obs_rvalid = r_valid;
    obs_rdata  = r_rdata;
  endtask

  task automatic idle_inputs();
    req   = '0;
    wen   = '1;
    add   = '0;
    wdata = '0;
    be    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_tests++; if (obs_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b want=0000", obs_gnt); end
      n_tests++; if (obs_bus !== exp_bus) begin n_fail++; $display("FAIL reset_bus got=%h want=%h", obs_bus, exp_bus); end
      n_tests++; if (obs_rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid got=%b want=0000", obs_rvalid); end
    end
    rst = 1'b0;
    req = 4'b1111;
    for (int m = 0; m < NB; m++) add[m] = AW'(16 + m);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++; if (obs_gnt !== (4'b0001 << (i % NB)) || obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_seq[%0d] got=%b want=%b", i, obs_gnt, exp_gnt); end
      n_tests++; if (obs_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rr_rvalid[%0d] got=%b want=%b", i, obs_rvalid, exp_rvalid); end
    end
    idle_inputs();
  endtask

  task automatic test_read_path();
    req = 4'b0100; wen[2] = 1'b0; add[2] = 8'd5; wdata[2] = 32'hDEADBEEF; be[2] = 4'hF;
    cycle();
    n_tests++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL wr_gnt got=%b want=0100", obs_gnt); end
    n_tests++; if (obs_bus !== exp_bus) begin n_fail++; $display("FAIL wr_bus got=%h want=%h", obs_bus, exp_bus); end
    n_tests++; if (obs_rvalid !== 4'b0100) begin n_fail++; $display("FAIL wr_rvalid got=%b want=0100", obs_rvalid); end
    wen[2] = 1'b1;
    cycle();
    n_tests++; if (obs_rvalid !== 4'b0100) begin n_fail++; $display("FAIL rd_rvalid got=%b want=0100", obs_rvalid); end
    n_tests++; if (obs_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h want=deadbeef", obs_rdata); end
    idle_inputs();
  endtask

  task automatic test_byte_enable();
    req = 4'b0010; add[1] = 8'd9;
    wen[1] = 1'b0; wdata[1] = 32'hFFFFFFFF; be[1] = 4'hF;
    cycle();
    wdata[1] = 32'h11223344; be[1] = 4'b0101;
    cycle();
    n_tests++; if (obs_bus !== exp_bus) begin n_fail++; $display("FAIL be_bus got=%h want=%h", obs_bus, exp_bus); end
    wen[1] = 1'b1;
    cycle();
    n_tests++; if (obs_rdata !== 32'hFF22FF44 || obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL be_merge got=%h want=ff22ff44", obs_rdata); end
    idle_inputs();
  endtask

  task automatic test_wrap_skip();
    req = 4'b0100;
    cycle();                  // m2 wins, pointer now 3
    req = 4'b0010;
    cycle();
    n_tests++; if (obs_gnt !== 4'b0010) begin n_fail++; $display("FAIL wrap_gnt got=%b want=0010", obs_gnt); end
    req = 4'b1010;            // pointer now 2: m3 ahead of m1
    cycle();
    n_tests++; if (obs_gnt !== 4'b1000) begin n_fail++; $display("FAIL skip_gnt got=%b want=1000", obs_gnt); end
    n_tests++; if (obs_rvalid !== 4'b1000) begin n_fail++; $display("FAIL skip_rvalid got=%b want=1000", obs_rvalid); end
    idle_inputs();
  endtask

  task automatic test_single_requester();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      add[2] = AW'(i);
      cycle();
      n_tests++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt[%0d] got=%b want=0100", i, obs_gnt); end
      n_tests++; if (obs_rvalid !== 4'b0100) begin n_fail++; $display("FAIL single_rvalid[%0d] got=%b want=0100", i, obs_rvalid); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    req = 4'b0001;
    cycle();
    n_tests++; if (obs_gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt0 got=%b want=0001", obs_gnt); end
    rst = 1'b1; req = 4'b0010;
    cycle();
    n_tests++; if (obs_gnt !== 4'b0010 || obs_bus !== exp_bus) begin n_fail++; $display("FAIL mid_rst_gnt got=%b want=0010", obs_gnt); end
    n_tests++; if (obs_rvalid !== 4'b0000) begin n_fail++; $display("FAIL mid_drop got=%b want=0000", obs_rvalid); end
    rst = 1'b0; req = 4'b1100;
    cycle();
    n_tests++; if (obs_gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_post_gnt got=%b want=0100", obs_gnt); end
    n_tests++; if (obs_rvalid !== 4'b0100) begin n_fail++; $display("FAIL mid_post_rvalid got=%b want=0100", obs_rvalid); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req = NB'($urandom);
      wen = NB'($urandom);
      for (int m = 0; m < NB; m++) begin
        add[m]   = AW'($urandom_range(0, 15));
        wdata[m] = $urandom;
        be[m]    = BW'($urandom);
      end
      cycle();
      n_tests++; if (obs_gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d] got=%b want=%b", i, obs_gnt, exp_gnt); end
      n_tests++; if (obs_bus !== exp_bus) begin n_fail++; $display("FAIL rnd_bus[%0d] got=%h want=%h", i, obs_bus, exp_bus); end
      n_tests++; if (obs_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d] got=%b want=%b", i, obs_rvalid, exp_rvalid); end
      if (exp_rd_chk) begin
        n_tests++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d] got=%h want=%h", i, obs_rdata, exp_rdata); end
      end
    end
    idle_inputs();
  endtask

`ifdef TCDM_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req = 4'b0011;
    for (int i = 0; i < 10; i++) cycle();
    n_tests++; if (perf_stall[0] !== 16'd5) begin n_fail++; $display("FAIL perf_m0 got=%0d want=5", perf_stall[0]); end
    n_tests++; if (perf_stall[1] !== 16'd5) begin n_fail++; $display("FAIL perf_m1 got=%0d want=5", perf_stall[1]); end
    perf_clr = 1'b1;
    cycle();
    perf_clr = 1'b0;
    n_tests++; if (perf_stall[0] !== 16'd0 || perf_stall[1] !== 16'd0) begin n_fail++; $display("FAIL perf_clr got=%0d/%0d want=0/0", perf_stall[0], perf_stall[1]); end
    idle_inputs();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ptr   = 0;
    rst     = 1'b1;
`ifdef TCDM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    idle_inputs();
    test_reset();
    test_read_path();
    test_byte_enable();
    test_wrap_skip();
    test_single_requester();
    test_reset_mid();
    test_random();
`ifdef TCDM_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tcdm_bank_rr_arbiter.md
Name: tcdm_bank_rr_arbiter

Overview:
Round-robin arbiter that shares one single-port 32-bit TCDM bank (tc_sram, 1-cycle read latency) between NB_MASTERS requesters. It sits between the cluster interconnect master ports and one bank instance. It issues at most one bank access per cycle and routes the read response back to the granted master one cycle later. Bank-side signals use TCDM conventions: wen active-low, so wen=1 is a read.

Parameters:
NB_MASTERS, 4, number of requesters (2..8)
BANK_SIZE, 256, words per bank; ADDR_W = $clog2(BANK_SIZE)
DATA_W, 32, data width; BE_W = DATA_W/8

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
req_i  in  NB_MASTERS  per-master request
add_i  in  NB_MASTERS x ADDR_W  per-master word address
wen_i  in  NB_MASTERS  per-master write enable, active-low (1=read)
wdata_i  in  NB_MASTERS x DATA_W  per-master write data
be_i  in  NB_MASTERS x BE_W  per-master byte enables
gnt_o  out  NB_MASTERS  one-hot grant, combinational, same cycle as req
r_valid_o  out  NB_MASTERS  one-hot response valid, cycle after grant
r_rdata_o  out  DATA_W  response data, shared by all masters
bank_req_o  out  1  bank request
bank_wen_o  out  1  bank wen, active-low
bank_add_o  out  ADDR_W  bank address
bank_wdata_o  out  DATA_W  bank write data
bank_be_o  out  BE_W  bank byte enables
bank_rdata_i  in  DATA_W  bank read data, valid 1 cycle after bank_req_o

Behaviour:
- Reset: rr_ptr=0, r_valid_o=0, resp_idx=0. gnt_o and bank_req_o are combinational and are 0 whenever req_i=0.
- Arbitration: search req_i starting at index rr_ptr, wrapping modulo NB_MASTERS. The first asserted index k wins. gnt_o[k]=1 and bank_req_o=1. Bank data and address outputs are muxed from master k.
- When no request is pending: bank_req_o=0, bank_wen_o=1, and the other bank outputs are driven 0.
- Pointer update: when any grant is given, rr_ptr <= (k+1) mod NB_MASTERS. Otherwise rr_ptr holds. Wrap from NB_MASTERS-1 goes to 0.
- Fairness: a master holding req is granted within NB_MASTERS cycles.
- Response: registered r_valid_q <= gnt_o, so r_valid_o[k]=1 exactly one cycle after gnt_o[k]. This applies to both reads and writes.
- r_rdata_o = bank_rdata_i, passed through combinationally during the valid cycle. It is don't-care when r_valid_o=0.
- Back-to-back: a new grant can be issued in the same cycle as the previous response. Sustained throughput is 1 access per cycle.
- Single requester: granted every cycle with no bubble.
- Simultaneous requests with rr_ptr pointing at a requester: that requester wins.
- Reset mid-operation: any in-flight response is dropped (r_valid_o=0 in the cycle after rst_i), and rr_ptr=0. A grant given combinationally in the reset cycle is still presented to the bank. Masters must not rely on it.
- Masters hold req, add, wen, wdata and be stable until granted. The arbiter does not check this.

Optional Feature:
Macro TCDM_ARB_PERF_EN.
- Defined: adds input perf_clr_i (1) and output perf_stall_o (NB_MASTERS x 16).
  - Per-master counter increments when req_i[m] & ~gnt_o[m], saturating at 16'hFFFF.
  - perf_clr_i=1 zeroes all counters next cycle and takes precedence over increment.
  - Counters reset to 0 on rst_i.
- Undefined: ports are absent, no counter logic, and arbitration is identical.

Decomposition:
- Package tcdm_arb_pkg: localparam computation helpers for ADDR_W, BE_W and the pointer width $clog2(NB_MASTERS).
- Package tcdm_arb_pkg: typedef tcdm_req_t struct {add, wen, wdata, be} used for the per-master input mux.
- Sub-module rr_prio_sel: combinational rotate-priority selector. Input is a req vector plus rr_ptr. Outputs are the one-hot grant and the binary index.

Test Plan:
- Reset with all req high: after rst_i drops, with rr_ptr=0 and req=4'b1111, grants are 0,1,2,3,0 on consecutive cycles. r_valid_o follows each grant by 1 cycle.
- Read path: m2 writes 32'hDEADBEEF to addr 5 with be=4'hF, then reads addr 5. Expected: r_valid_o=4'b0100 one cycle after the read grant, and r_rdata_o=32'hDEADBEEF.
- Byte enables: m1 writes 32'h11223344 with be=4'b0101 over existing data 32'hFFFFFFFF. A subsequent read returns 32'hFF22FF44.
- Wrap and skip: rr_ptr=3, req=4'b0010 gives m1. The next request from m3 and m1 together gives m3, because rr_ptr=2.
- Reset mid-flight: assert rst_i in the cycle after m0's grant. Expected: r_valid_o=0 the next cycle, and the first post-reset grant goes to the lowest requester.
- PERF (TCDM_ARB_PERF_EN defined): m0 and m1 request continuously for 10 cycles. Expected: perf_stall_o[m0]=5 and [m1]=5. perf_clr_i then zeroes both.
